// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests instructions from memory, decodes the fixed fields,
// resolves JMP/HALT locally and hands every other instruction to the control unit.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE,
        HALT
    } state_t;

    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam int         JMP_W   = (PC_W < 4) ? PC_W : 4;

    state_t              state;
    state_t              state_next;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     jmp_target;
    logic [INSTR_W-1:0]  ir;
    logic [2:0]          fetched_op;
    logic                fetch_done;
    logic                issue_done;
    logic                unused_bits;

    assign fetched_op = imem_data[7:5];
    assign fetch_done = (state == REQ) && imem_ack;
    assign issue_done = (state == ISSUE) && out_ready;

    // JMP target is the low nibble of the instruction, resized to the PC width
    always_comb begin
        jmp_target              = '0;
        jmp_target[JMP_W-1:0]   = imem_data[JMP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    case (fetched_op)
                        OP_HALT: state_next = HALT;
                        OP_JMP:  state_next = REQ;
                        default: state_next = ISSUE;
                    endcase
                end
            end
            // en is only consulted here, so dropping it never aborts a transaction
            ISSUE: begin
                if (out_ready) begin
                    state_next = en ? REQ : IDLE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            ir     <= '0;
            pc_out <= '0;
        end else begin
            if (fetch_done) begin
                ir     <= imem_data;
                pc_out <= pc;
                if (fetched_op == OP_JMP) begin
                    pc <= jmp_target;
                end
            end
            if (issue_done) begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Outputs decode the state directly so reset clears them without waiting for a clock
    assign imem_req  = (state == REQ);
    assign out_valid = (state == ISSUE);
    assign halted    = (state == HALT);
    assign imem_addr = pc;
    assign opcode    = ir[7:5];
    assign rd        = ir[4:3];
    assign rs        = ir[2:1];

    assign unused_bits = ^ir;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level program model with
// randomized memory latency, downstream back-pressure and run-enable toggling.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 8;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic               en;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         opcode;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [PC_W-1:0]    pc_out;
    logic               halted;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];
    int ack_pct;
    int ready_pct;
    int en_flip_pct;

    // Program-level model: where the program counter is and what the fetcher is doing
    logic [3:0] m_pc;
    logic [3:0] m_ir_pc;
    logic [7:0] m_ir;
    bit         m_active;
    bit         m_issue;
    bit         m_halted;

    instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs        (rs),
        .pc_out    (pc_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model, drive random inputs, advance the model
    task automatic applyStimulus();
        bit fetching;
        fetching = m_active && !m_issue && !m_halted;
        checkOutput("imem_req", imem_req, fetching);
        checkOutput("out_valid", out_valid, m_issue);
        checkOutput("halted", halted, m_halted);
        checkOutput("imem_addr", imem_addr, m_pc);
        if (m_issue) begin
            checkOutput("opcode", opcode, m_ir[7:5]);
            checkOutput("rd", rd, m_ir[4:3]);
            checkOutput("rs", rs, m_ir[2:1]);
            checkOutput("pc_out", pc_out, m_ir_pc);
        end

        if ($urandom_range(0, 99) < en_flip_pct) en = ~en;
        imem_ack  = ($urandom_range(0, 99) < ack_pct);
        imem_data = (fetching && imem_ack) ? mem[m_pc] : 8'($urandom);
        out_ready = ($urandom_range(0, 99) < ready_pct);

        if (!m_halted) begin
            if (m_issue) begin
                if (out_ready) begin
                    m_pc     = 4'((int'(m_pc) + 1) % 16);
                    m_issue  = 1'b0;
                    m_active = en;
                end
            end else if (m_active) begin
                if (imem_ack) begin
                    m_ir    = imem_data;
                    m_ir_pc = m_pc;
                    case (imem_data[7:5])
                        3'b111:  m_halted = 1'b1;
                        3'b110:  m_pc = imem_data[3:0];
                        default: m_issue = 1'b1;
                    endcase
                end
            end else if (en) begin
                m_active = 1'b1;
            end
        end

        @(posedge clk);
        #1;
    endtask

    // Asserts reset at the current time, checks that outputs clear at once, releases on a falling edge
    task automatic doReset();
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        out_ready = 1'b0;
        m_pc      = '0;
        m_ir_pc   = '0;
        m_ir      = '0;
        m_active  = 1'b0;
        m_issue   = 1'b0;
        m_halted  = 1'b0;
        #1;
        checkOutput("rst_imem_req", imem_req, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_halted", halted, 1'b0);
        checkOutput("rst_imem_addr", imem_addr, 4'd0);
        checkOutput("rst_pc_out", pc_out, 4'd0);
        checkOutput("rst_fields", {opcode, rd, rs}, 7'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] word;
        bit         reached;

        en          = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = '0;
        out_ready   = 1'b0;
        ack_pct     = 100;
        ready_pct   = 100;
        en_flip_pct = 0;

        // Directed program: ALU ops everywhere, a JMP to 10 at address 3
        for (int i = 0; i < 16; i++) begin
            mem[i] = {3'($urandom_range(0, 5)), 5'($urandom)};
        end
        mem[0] = 8'b001_01_10_0;
        mem[3] = 8'b110_0_1010;

        doReset();
        en = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("first_valid", out_valid, 1'b1);
        checkOutput("first_opcode", opcode, 3'b001);
        checkOutput("first_rd", rd, 2'b01);
        checkOutput("first_rs", rs, 2'b10);
        checkOutput("first_pc_out", pc_out, 4'd0);

        ready_pct = 0;
        repeat (5) applyStimulus();
        checkOutput("stall_valid", out_valid, 1'b1);
        checkOutput("stall_pc", imem_addr, 4'd0);
        ready_pct = 100;
        applyStimulus();
        checkOutput("after_handshake_addr", imem_addr, 4'd1);

        // Runs through the JMP at 3 and the wrap from 15 back to 0
        repeat (30) applyStimulus();

        for (int i = 0; i < 16; i++) begin
            do word = 8'($urandom); while (word[7:5] == 3'b111);
            mem[i] = word;
        end
        ack_pct     = 40;
        ready_pct   = 50;
        en_flip_pct = 8;
        repeat (1500) applyStimulus();

        // Reset landing mid-REQ (mode 0) and mid-ISSUE (mode 1), away from any clock edge
        en_flip_pct = 0;
        for (int mode = 0; mode < 2; mode++) begin
            en = 1'b1;
            doReset();
            ack_pct   = (mode == 1) ? 100 : 0;
            ready_pct = 0;
            reached   = 1'b0;
            for (int k = 0; k < 20 && !reached; k++) begin
                applyStimulus();
                reached = (mode == 1) ? m_issue : (m_active && !m_issue);
            end
            checkOutput("busy_before_reset", reached, 1'b1);
            checkOutput("busy_output", (mode == 1) ? out_valid : imem_req, 1'b1);
            #2;
            doReset();
            ack_pct   = 100;
            ready_pct = 100;
            repeat (6) applyStimulus();
        end

        // HALT: stays halted despite stray acks until reset
        mem[0]   = 8'b111_00000;
        en       = 1'b1;
        ack_pct  = 100;
        doReset();
        repeat (12) applyStimulus();
        checkOutput("halt_flag", halted, 1'b1);
        checkOutput("halt_no_req", imem_req, 1'b0);
        doReset();
        checkOutput("halt_cleared", halted, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
